// File: rtl/apb_pkg.sv
// Types and constants shared by the APB bridge endpoints (apb_master / apb_slave).
package apb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_SIZE  = 4;
  localparam int unsigned WCNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_t;

endpackage

// File: rtl/apb_slave_if.sv
// APB bus bundle between a completer and its requester.
// slverr exists only when APB_SLAVE_SLVERR_EN is defined.
interface apb_slave_if #(
  parameter int unsigned ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int unsigned STRB_SIZE  = apb_pkg::STRB_SIZE
);
  logic                  sel;
  logic                  enable;
  logic                  write;
  logic [STRB_SIZE-1:0]  strb;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
`ifdef APB_SLAVE_SLVERR_EN
  logic                  slverr;
`endif

  modport master (
    output sel, enable, write, strb, addr, wdata,
    input  rdata, ready
`ifdef APB_SLAVE_SLVERR_EN
    , input slverr
`endif
  );

  modport slave (
    input  sel, enable, write, strb, addr, wdata,
    output rdata, ready
`ifdef APB_SLAVE_SLVERR_EN
    , output slverr
`endif
  );

endinterface

// File: rtl/apb_slave_mem.sv
// Word-addressed register array with per-byte-lane write enables,
// asynchronous clear and a combinational read port.
module apb_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_SIZE  = 4,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [STRB_SIZE-1:0]  i_strb,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata_c
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < int'(STRB_SIZE); b++) begin
        if (i_strb[b]) begin
          r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/apb_slave.sv
// APB completer: phase decode, programmable wait states, byte-strobed register array.
// Optional error response on out-of-range or empty-strobe access via APB_SLAVE_SLVERR_EN.
module apb_slave #(
  parameter int unsigned ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = apb_pkg::DATA_WIDTH,
  parameter int unsigned STRB_SIZE   = apb_pkg::STRB_SIZE,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  apb_slave_if.slave bus
);
  import apb_pkg::*;

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  apb_phase_t            r_state;
  apb_phase_t            w_state_next;
  apb_phase_t            w_phase;
  logic [WCNT_WIDTH-1:0] r_wcnt;
  logic [WCNT_WIDTH-1:0] w_wcnt_next;
  logic                  w_ready;
  logic                  w_in_range;
  logic                  w_we;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // r_state holds the phase reached at the previous edge; w_phase is the
  // phase of the current bus cycle, so ready can fire in the first ACCESS cycle.
  always_comb begin
    w_phase      = IDLE;
    w_state_next = IDLE;
    w_wcnt_next  = r_wcnt;
    w_ready      = 1'b0;

    case (r_state)
      IDLE:    if (bus.sel && !bus.enable) w_phase = SETUP;
      SETUP:   if (bus.sel && bus.enable)  w_phase = ACCESS;
      ACCESS:  if (bus.sel)                w_phase = bus.enable ? ACCESS : SETUP;
      default: w_phase = IDLE;
    endcase

    w_ready = (w_phase == ACCESS) && (r_wcnt == WCNT_WIDTH'(WAIT_CYCLES));

    // A completed transfer parks in IDLE; a follow-on SETUP is decoded from there.
    w_state_next = w_ready ? IDLE : w_phase;

    if (w_phase == SETUP) begin
      w_wcnt_next = '0;
    end else if ((w_phase == ACCESS) && !w_ready) begin
      w_wcnt_next = r_wcnt + WCNT_WIDTH'(1);
    end
  end

  assign w_in_range = (bus.addr < ADDR_WIDTH'(MEM_DEPTH));
  assign w_idx      = bus.addr[IDX_W-1:0];
  assign w_we       = w_ready && bus.write && w_in_range;

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_SIZE  (STRB_SIZE),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_idx     (w_idx),
    .i_strb    (bus.strb),
    .i_wdata   (bus.wdata),
    .o_rdata_c (w_mem_rdata)
  );

  assign bus.ready = w_ready;
  assign bus.rdata = (w_ready && !bus.write && w_in_range) ? w_mem_rdata : '0;

`ifdef APB_SLAVE_SLVERR_EN
  assign bus.slverr = w_ready && (!w_in_range || (bus.write && (bus.strb == '0)));
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Randomized scoreboard bench for apb_slave (WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance).
module tb_apb_slave;
  import apb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WAIT  = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  exp_t        sb_q [$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  apb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_SIZE(SW)) bus ();
  apb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_SIZE(SW)) bus0 ();

  apb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_SIZE(SW),
              .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  apb_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_SIZE(SW),
              .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
  endtask

  // Issue one transfer on the WAIT=2 bus; the expected response goes to the scoreboard.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    exp_t e;
    int   n;
    e.rdata  = 32'h0;
    e.slverr = (a >= DEPTH) || (wr && (s == 4'h0));
    if (wr) begin
      if (a < DEPTH)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      e.rdata = (a < DEPTH) ? model[a] : 32'h0;
    end
    sb_q.push_back(e);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = wr;
    bus.addr = a; bus.wdata = d; bus.strb = s;
    @(posedge clk); #1 bus.enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 40);
    if (!bus.ready) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: no ready after %0d cycles, addr %h", n, a);
    end
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Direct transfer on the WAIT=0 bus: ready must be high in the first ACCESS cycle.
  task automatic xfer0(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd);
    bus0.sel = 1'b1; bus0.enable = 1'b0; bus0.write = wr;
    bus0.addr = a; bus0.wdata = d; bus0.strb = s;
    #1 chk("w0_setup_ready", 32'(bus0.ready), 32'h0);
    @(posedge clk); #1 bus0.enable = 1'b1;
    #1 chk("w0_first_access_ready", 32'(bus0.ready), 32'h1);
    chk("w0_rdata", bus0.rdata, exp_rd);
    @(posedge clk); #1;
    bus0.sel = 1'b0; bus0.enable = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every completion, checks data, length and idle rdata.
  initial begin
    int   cyc;
    int   start;
    exp_t e;
    cyc = 0;
    start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) continue;
      if (bus.sel && !bus.enable) start = cyc;
      if (bus.ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: ready with empty scoreboard at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", bus.rdata, e.rdata);
          chk("xfer_len", 32'(cyc - start + 1), 32'(2 + WAIT));
`ifdef APB_SLAVE_SLVERR_EN
          chk("slverr", 32'(bus.slverr), 32'(e.slverr));
`endif
        end
      end else if (bus.sel) begin
        chk("rdata_idle", bus.rdata, 32'h0);
`ifdef APB_SLAVE_SLVERR_EN
        chk("slverr_idle", 32'(bus.slverr), 32'h0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    model_clear();
    bus.sel = 1'b0;  bus.enable = 1'b0;  bus.write = 1'b0;
    bus.addr = '0;   bus.wdata = '0;     bus.strb = '0;
    bus0.sel = 1'b0; bus0.enable = 1'b0; bus0.write = 1'b0;
    bus0.addr = '0;  bus0.wdata = '0;    bus0.strb = '0;

    #1;
    chk("reset_ready", 32'(bus.ready), 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_ready0", 32'(bus0.ready), 32'h0);
`ifdef APB_SLAVE_SLVERR_EN
    chk("reset_slverr", 32'(bus.slverr), 32'h0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Write then read
    xfer(1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
    idle(1);
    xfer(1'b0, 32'd3, 32'h0, 4'h0);
    idle(2);

    // Partial strobe, back-to-back
    xfer(1'b1, 32'd5, 32'h11223344, 4'hF);
    xfer(1'b1, 32'd5, 32'hAABBCCDD, 4'b0101);
    xfer(1'b0, 32'd5, 32'h0, 4'h0);
    idle(1);

    // Three back-to-back writes, then back-to-back reads
    xfer(1'b1, 32'd8,  32'h01010101, 4'hF);
    xfer(1'b1, 32'd9,  32'h02020202, 4'hF);
    xfer(1'b1, 32'd10, 32'h03030303, 4'hF);
    xfer(1'b0, 32'd8,  32'h0, 4'h0);
    xfer(1'b0, 32'd9,  32'h0, 4'h0);
    xfer(1'b0, 32'd10, 32'h0, 4'h0);
    idle(1);

    // Out of range
    xfer(1'b1, 32'd16, 32'hFFFFFFFF, 4'hF);
    xfer(1'b0, 32'd16, 32'h0, 4'h0);
    xfer(1'b0, 32'd0,  32'h0, 4'h0);
    xfer(1'b1, 32'd4,  32'h55555555, 4'h0);
    xfer(1'b0, 32'd4,  32'h0, 4'h0);
    idle(1);

    // Aborted transfer: sel dropped during a wait state
    xfer(1'b1, 32'd7, 32'h0BADCAFE, 4'hF);
    idle(1);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
    bus.addr = 32'd7; bus.wdata = 32'hFFFFFFFF; bus.strb = 4'hF;
    @(posedge clk); #1 bus.enable = 1'b1;
    @(posedge clk); #1 bus.sel = 1'b0; bus.enable = 1'b0;
    idle(2);
    xfer(1'b0, 32'd7, 32'h0, 4'h0);
    idle(1);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 19));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      xfer(wr, a, d, s);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    // Reset in the second ACCESS cycle of a write; the WAIT=0 bus is completing at that moment
    xfer(1'b1, 32'd1, 32'h12345678, 4'hF);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
    bus.addr = 32'd1; bus.wdata = 32'hA5A5A5A5; bus.strb = 4'hF;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    bus0.sel = 1'b1; bus0.enable = 1'b0; bus0.write = 1'b0; bus0.addr = 32'd2;
    @(posedge clk); #1;
    bus0.enable = 1'b1;
    #1;
    chk("pre_rst_ready0", 32'(bus0.ready), 32'h1);
    chk("pre_rst_ready", 32'(bus.ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_ready0_drop", 32'(bus0.ready), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    bus.sel = 1'b0;  bus.enable = 1'b0;
    bus0.sel = 1'b0; bus0.enable = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // From IDLE, an ACCESS without SETUP must not complete
    bus.sel = 1'b1; bus.enable = 1'b1; bus.write = 1'b0; bus.addr = 32'd1;
    #1 chk("no_setup_ready", 32'(bus.ready), 32'h0);
    repeat (3) begin
      @(posedge clk); #2;
      chk("no_setup_ready", 32'(bus.ready), 32'h0);
    end
    bus.sel = 1'b0; bus.enable = 1'b0;
    idle(1);
    xfer(1'b0, 32'd1, 32'h0, 4'h0);
    idle(1);

    // WAIT_CYCLES=0 instance
    xfer0(1'b1, 32'd2,  32'hCAFEF00D, 4'hF, 32'h0);
    xfer0(1'b0, 32'd2,  32'h0,        4'h0, 32'hCAFEF00D);
    xfer0(1'b1, 32'd2,  32'h000000EE, 4'b0001, 32'h0);
    xfer0(1'b0, 32'd2,  32'h0,        4'h0, 32'hCAFEF0EE);
    xfer0(1'b0, 32'd20, 32'h0,        4'h0, 32'h0);
    idle(3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
